// File: rtl/app_reg_resp.sv
// Two independent register channels: each captures a host write and returns
// write+1 as the device read value, with a sticky valid flag.

module app_reg_resp_chan #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] wr,
   input  logic         wr_en,
   output logic [W-1:0] rd,
   output logic         rd_valid,
   output logic [W-1:0] wr_q
);

   logic [W-1:0] rd_reg;
   logic [W-1:0] wr_q_reg;
   logic         valid_reg;
   logic [W-1:0] rd_next;

   // Increment wraps silently at the channel width; no carry-out is kept.
   assign rd_next = wr + W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_reg    <= '0;
         wr_q_reg  <= '0;
         valid_reg <= 1'b0;
      end else if (wr_en) begin
         rd_reg    <= rd_next;
         wr_q_reg  <= wr;
         valid_reg <= 1'b1;
      end
   end

   assign rd       = rd_reg;
   assign wr_q     = wr_q_reg;
   assign rd_valid = valid_reg;

endmodule

module app_reg_resp #(
   parameter int BASE_W    = 8,
   parameter int EXAMPLE_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BASE_W-1:0]    base_wr,
   input  logic                 base_wr_en,
   output logic [BASE_W-1:0]    base_rd,
   output logic                 base_rd_valid,
   output logic [BASE_W-1:0]    base_wr_q,
   input  logic [EXAMPLE_W-1:0] example_wr,
   input  logic                 example_wr_en,
   output logic [EXAMPLE_W-1:0] example_rd,
   output logic                 example_rd_valid,
   output logic [EXAMPLE_W-1:0] example_wr_q
);

   app_reg_resp_chan #(.W(BASE_W)) u_base (
      .clk      (clk),
      .rst      (rst),
      .wr       (base_wr),
      .wr_en    (base_wr_en),
      .rd       (base_rd),
      .rd_valid (base_rd_valid),
      .wr_q     (base_wr_q)
   );

   app_reg_resp_chan #(.W(EXAMPLE_W)) u_example (
      .clk      (clk),
      .rst      (rst),
      .wr       (example_wr),
      .wr_en    (example_wr_en),
      .rd       (example_rd),
      .rd_valid (example_rd_valid),
      .wr_q     (example_wr_q)
   );

endmodule

// File: tb/tb_app_reg_resp.sv
// Directed and randomized checks of app_reg_resp against a simple arithmetic model.

module tb_app_reg_resp;

   localparam int BASE_W    = 8;
   localparam int EXAMPLE_W = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [BASE_W-1:0]    base_wr = '0;
   logic                 base_wr_en = 1'b0;
   logic [BASE_W-1:0]    base_rd;
   logic                 base_rd_valid;
   logic [BASE_W-1:0]    base_wr_q;
   logic [EXAMPLE_W-1:0] example_wr = '0;
   logic                 example_wr_en = 1'b0;
   logic [EXAMPLE_W-1:0] example_rd;
   logic                 example_rd_valid;
   logic [EXAMPLE_W-1:0] example_wr_q;

   int checks = 0;
   int errors = 0;

   // Reference state: plain integers updated from the channel rules
   int m_b_q, m_b_rd, m_b_v;
   int m_e_q, m_e_rd, m_e_v;

   always #5 clk = ~clk;

   app_reg_resp #(.BASE_W(BASE_W), .EXAMPLE_W(EXAMPLE_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .base_wr          (base_wr),
      .base_wr_en       (base_wr_en),
      .base_rd          (base_rd),
      .base_rd_valid    (base_rd_valid),
      .base_wr_q        (base_wr_q),
      .example_wr       (example_wr),
      .example_wr_en    (example_wr_en),
      .example_rd       (example_rd),
      .example_rd_valid (example_rd_valid),
      .example_wr_q     (example_wr_q)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, update model at posedge, compare just after.
   task automatic step(input logic r, input logic ben, input int bwr,
                       input logic een, input int ewr);
      @(negedge clk);
      rst           = r;
      base_wr_en    = ben;
      base_wr       = BASE_W'(bwr);
      example_wr_en = een;
      example_wr    = EXAMPLE_W'(ewr);
      @(posedge clk);
      if (r) begin
         m_b_q = 0; m_b_rd = 0; m_b_v = 0;
         m_e_q = 0; m_e_rd = 0; m_e_v = 0;
      end else begin
         if (ben) begin
            m_b_q  = bwr % (1 << BASE_W);
            m_b_rd = (m_b_q + 1) % (1 << BASE_W);
            m_b_v  = 1;
         end
         if (een) begin
            m_e_q  = ewr % (1 << EXAMPLE_W);
            m_e_rd = (m_e_q + 1) % (1 << EXAMPLE_W);
            m_e_v  = 1;
         end
      end
      #1;
      check("base_rd",          32'(base_rd),          32'(m_b_rd));
      check("base_wr_q",        32'(base_wr_q),        32'(m_b_q));
      check("base_rd_valid",    32'(base_rd_valid),    32'(m_b_v));
      check("example_rd",       32'(example_rd),       32'(m_e_rd));
      check("example_wr_q",     32'(example_wr_q),     32'(m_e_q));
      check("example_rd_valid", 32'(example_rd_valid), 32'(m_e_v));
      $display("cyc rst=%0b b_en=%0b b_wr=%02h e_en=%0b e_wr=%04h -> b_rd=%02h b_q=%02h b_v=%0b e_rd=%04h e_q=%04h e_v=%0b",
               r, ben, bwr[7:0], een, ewr[15:0], base_rd, base_wr_q, base_rd_valid,
               example_rd, example_wr_q, example_rd_valid);
   endtask

   initial begin
      // Reset with strobes high and random data
      for (int i = 0; i < 2; i++)
         step(1'b1, 1'b1, int'($urandom_range(0, 255)), 1'b1, int'($urandom_range(0, 65535)));
      check("reset_base_rd", 32'(base_rd), 32'h0);
      check("reset_example_valid", 32'(example_rd_valid), 32'h0);

      // Basic simultaneous write
      step(1'b0, 1'b1, 'hAB, 1'b1, 'hCDEF);
      check("basic_base_rd",    32'(base_rd),    32'hAC);
      check("basic_example_rd", 32'(example_rd), 32'hCDF0);

      // Hold with changing inputs
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b0, int'($urandom_range(0, 255)), 1'b0, int'($urandom_range(0, 65535)));
      check("hold_base_wr_q",    32'(base_wr_q),    32'hAB);
      check("hold_example_wr_q", 32'(example_wr_q), 32'hCDEF);

      // Wrap-around
      step(1'b0, 1'b1, 'hFF, 1'b1, 'hFFFF);
      check("wrap_base_rd",    32'(base_rd),    32'h00);
      check("wrap_example_rd", 32'(example_rd), 32'h0000);
      check("wrap_base_valid", 32'(base_rd_valid), 32'h1);

      // Back-to-back base-only writes
      for (int i = 1; i <= 3; i++) begin
         step(1'b0, 1'b1, i, 1'b0, int'($urandom_range(0, 65535)));
         check("b2b_base_rd", 32'(base_rd), 32'(i + 1));
         check("b2b_example_wr_q", 32'(example_wr_q), 32'hFFFF);
      end

      // Reset colliding with a write
      step(1'b1, 1'b1, 'h10, 1'b0, 0);
      check("collide_base_rd",    32'(base_rd),       32'h0);
      check("collide_base_wr_q",  32'(base_wr_q),     32'h0);
      check("collide_base_valid", 32'(base_rd_valid), 32'h0);

      // Randomized traffic with occasional reset
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 39) == 0),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
